// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end.
//   XLEN             : architectural register / address width
//   DEFAULT_RESET_PC : fetch address used after reset unless overridden
//   fetch_state_e    : instruction fetch FSM encoding
//   OPC_*            : major opcodes (instr[6:0]) shared with main_decoder
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FetchIdle  = 2'd0,
        FetchWait  = 2'd1,
        FetchFlush = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : discard all entries (wins over push/pop)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : drop head entry (ignored when empty)
//   rdata_o      : head entry
//   count_o      : number of valid entries
//   empty_o      : no valid entries
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, buffers returned words in fetch_fifo and hands them to decode.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   imem_req_o/addr_o/gnt_i   : request channel to instruction memory
//   imem_rvalid_i/rdata_i     : response channel (one response per grant)
//   redirect_i/redirect_pc_i  : taken control transfer, flush and refetch
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : handshake to decode
//   misalign_o                : sticky flag, last redirect target misaligned
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        misalign_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             misalign_q, misalign_d;

    logic [CNT_W-1:0] count;
    logic             empty;
    logic [63:0]      head;
    logic             push;
    logic             pop;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i ({pend_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty)
    );

    // The buffer only grows in WAIT, so the request stays stable until granted
    // unless a redirect moves the fetch pc.
    assign imem_req_o    = (state_q == FetchIdle) && (count < CNT_W'(BUF_DEPTH)) && !misalign_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = !empty;
    assign instr_o       = head[31:0];
    assign instr_pc_o    = head[63:32];
    assign misalign_o    = misalign_q;

    // Redirect also drives the FIFO flush, which overrides these.
    assign push = (state_q == FetchWait) && imem_rvalid_i;
    assign pop  = instr_valid_o && instr_ready_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        misalign_d = misalign_q;

        case (state_q)
            FetchIdle: begin
                if (imem_req_o && imem_gnt_i) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = FetchWait;
                end
            end
            FetchWait, FetchFlush: begin
                if (imem_rvalid_i) begin
                    state_d = FetchIdle;
                end
            end
            default: state_d = FetchIdle;
        endcase

        if (redirect_i) begin
            pc_d       = redirect_pc_i;
            misalign_d = |redirect_pc_i[1:0];
            // A request still in flight must be drained in FLUSH; a response
            // arriving this cycle is dropped by the FIFO flush.
            case (state_q)
                FetchIdle:  state_d = (imem_req_o && imem_gnt_i) ? FetchFlush : FetchIdle;
                FetchWait:  state_d = imem_rvalid_i ? FetchIdle : FetchFlush;
                FetchFlush: state_d = imem_rvalid_i ? FetchIdle : FetchFlush;
                default:    state_d = FetchIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FetchIdle;
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 BUF_DEPTH, 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 imem_req_o  output  1  fetch request to instruction memory.
REQ-006 imem_addr_o  output  32  fetch address, word-aligned.
REQ-007 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid_i  input  1  read data valid; exactly one per grant, at least 1 cycle after grant.
REQ-009 imem_rdata_i  input  32  fetched instruction word.
REQ-010 redirect_i  input  1  branch/jump/jalr taken; flush and refetch.
REQ-011 redirect_pc_i  input  32  new fetch address when redirect_i=1.
REQ-012 instr_valid_o  output  1  instr_o/instr_pc_o valid toward decode.
REQ-013 instr_o  output  32  instruction word; bits [6:0] drive the decoder opcode input.
REQ-014 instr_pc_o  output  32  address of instr_o.
REQ-015 instr_ready_i  input  1  decode consumes the head entry when instr_valid_o=1.
REQ-016 misalign_o  output  1  sticky: last redirect target had [1:0]!=0.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, FLUSH; at most one request outstanding at any time.
REQ-018 IDLE: imem_req_o SHALL be 1 iff (buffer count + 0) < BUF_DEPTH and misalign_o=0; imem_req_o and imem_addr_o SHALL hold stable until imem_gnt_i.
REQ-019 IDLE with req and gnt: the fetch pc SHALL advance by 4 and the state SHALL go to WAIT; the issued address SHALL be captured as the pc of the pending response.
REQ-020 WAIT with rvalid: {rdata, pending pc} SHALL be pushed into the buffer and the state SHALL go to IDLE; imem_req_o SHALL be 0 in WAIT.
REQ-021 Latency: rvalid in cycle n SHALL give instr_valid_o=1 in cycle n+1 when the buffer was empty.
REQ-022 Decode handshake: an entry is popped when instr_valid_o=1 and instr_ready_i=1; outputs SHALL hold stable while instr_ready_i=0; push and pop in the same cycle SHALL leave count unchanged.
REQ-023 Buffer full: no request SHALL be issued; a response can never arrive when full, by REQ-018.
REQ-024 Redirect, any state: the buffer SHALL be cleared the next cycle (instr_valid_o=0), and the fetch pc SHALL be set to redirect_pc_i; redirect SHALL take priority over a same-cycle pop or push.
REQ-025 Redirect in IDLE with no same-cycle grant: the state SHALL stay IDLE, and the next request SHALL use redirect_pc_i.
REQ-026 Redirect in IDLE with a same-cycle grant, or in WAIT without rvalid: the state SHALL go to FLUSH.
REQ-027 Redirect in WAIT with a same-cycle rvalid: the response SHALL be dropped and the state SHALL go to IDLE.
REQ-028 FLUSH: rvalid SHALL be discarded and the state SHALL go to IDLE; a further redirect SHALL update the fetch pc and keep the state in FLUSH; imem_req_o SHALL be 0.
REQ-029 Redirect with redirect_pc_i[1:0]!=0: misalign_o SHALL be set and fetching SHALL stall; only an aligned redirect SHALL clear misalign_o.
REQ-030 The fetch pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Reset
REQ-031 With rst_i=1 at a clock edge: state=IDLE, fetch pc=RESET_PC, buffer count=0, misalign_o=0, instr_valid_o=0.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding response, and the bench SHALL not deliver it afterward; imem_req_o SHALL be 1 in the first cycle after rst_i deasserts.

Structure
REQ-033 Package riscv_pkg SHALL hold XLEN=32, the default RESET_PC, the fetch state enum, and the opcode constants shared with main_decoder.
REQ-034 A sub-module fetch_fifo (synchronous, BUF_DEPTH x 64-bit {pc,instr}, push/pop/flush, count) SHALL implement the buffer.

Verification
REQ-035 Reset, gnt=1, rvalid 1 cycle later with 0x00000013, ready=1 -> addresses 0x0,0x4,0x8; instr_o=0x00000013 with instr_pc_o=0x0 one cycle after the first rvalid.
REQ-036 ready=0 held -> exactly BUF_DEPTH fetches, then imem_req_o=0; ready=1 -> entries delivered in order, and fetching resumes.
REQ-037 Redirect to 0x100 while in WAIT, with the stale rvalid 2 cycles later -> stale word never appears; next request address is 0x100.
REQ-038 Redirect and rvalid in the same cycle in WAIT -> response dropped; next request is 0x100; instr_valid_o=0 until the 0x100 data arrives.
REQ-039 Redirect to 0x102 -> misalign_o=1, no requests; then redirect to 0x200 -> misalign_o=0, request at 0x200.
REQ-040 rst_i pulsed in WAIT -> all outputs at reset values; the first request after reset is RESET_PC.
